// File: rtl/instr_sequencer.sv
// Four-state instruction sequencer: accepts one 8-bit instruction, walks DECODE/EXECUTE/WRITEBACK, counts retires.
// Latency: accept at edge T, we in cycle after T+2, ready again after T+3 (NOP after T+2); ready only in IDLE.
module instr_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [7:0]       instr,
    output logic             instr_ready,
    output logic [1:0]       src_a,
    output logic [1:0]       src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       dest_reg,
    output logic             we,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b11;

    state_t     state, state_nxt;
    logic [7:0] instr_q, instr_q_nxt;

    always_comb begin
        state_nxt   = state;
        instr_q_nxt = instr_q;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    state_nxt   = DECODE;
                    instr_q_nxt = instr;
                end
            end
            DECODE:    state_nxt = EXECUTE;
            EXECUTE:   state_nxt = (instr_q[7:6] == OP_NOP) ? IDLE : WRITEBACK;
            WRITEBACK: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they always reflect the current state and instr_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            instr_q     <= 8'd0;
            instr_count <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            src_a       <= 2'd0;
            src_b       <= 2'd0;
            alu_op      <= 2'd0;
            dest_reg    <= 2'd0;
            we          <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            instr_q     <= instr_q_nxt;
            if (done) begin
                instr_count <= instr_count + 1'b1;
            end
            instr_ready <= (state_nxt == IDLE);
            busy        <= (state_nxt != IDLE);
            src_a       <= (state_nxt != IDLE) ? instr_q_nxt[3:2] : 2'd0;
            src_b       <= (state_nxt != IDLE) ? instr_q_nxt[1:0] : 2'd0;
            dest_reg    <= (state_nxt != IDLE) ? instr_q_nxt[5:4] : 2'd0;
            alu_op      <= (state_nxt == EXECUTE) ? instr_q_nxt[7:6] : 2'd0;
            we          <= (state_nxt == WRITEBACK);
            done        <= (state_nxt == WRITEBACK) ||
                           ((state_nxt == EXECUTE) && (instr_q_nxt[7:6] == OP_NOP));
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios then random traffic against a per-instruction timeline model.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr;

    logic       a_ready, a_we, a_busy, a_done;
    logic [1:0] a_src_a, a_src_b, a_alu_op, a_dest;
    logic [7:0] a_count;
    logic       b_ready, b_we, b_busy, b_done;
    logic [1:0] b_src_a, b_src_b, b_alu_op, b_dest;
    logic [1:0] b_count;

    always #5 clk = ~clk;

    instr_sequencer #(.CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(a_ready), .src_a(a_src_a), .src_b(a_src_b), .alu_op(a_alu_op),
        .dest_reg(a_dest), .we(a_we), .busy(a_busy), .done(a_done), .instr_count(a_count)
    );

    instr_sequencer #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(b_ready), .src_a(b_src_a), .src_b(b_src_b), .alu_op(b_alu_op),
        .dest_reg(b_dest), .we(b_we), .busy(b_busy), .done(b_done), .instr_count(b_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: age = cycles since acceptance (0 = idle); an instruction lives 3 cycles, a NOP 2.
    int         age   = 0;
    logic [7:0] cur   = 8'd0;
    int         count = 0;
    int         we_cycle_log[$];
    int         dest_log[$];
    int         cyc = 0;

    function automatic int life(input logic [7:0] x);
        return (x[7:6] == 2'b11) ? 2 : 3;
    endfunction

    task automatic compare_all();
        logic [1:0] e_src_a, e_src_b, e_alu, e_dest;
        logic       e_ready, e_we, e_done;
        e_ready = (age == 0);
        e_src_a = (age != 0) ? cur[3:2] : 2'd0;
        e_src_b = (age != 0) ? cur[1:0] : 2'd0;
        e_dest  = (age != 0) ? cur[5:4] : 2'd0;
        e_alu   = (age == 2) ? cur[7:6] : 2'd0;
        e_we    = (age == 3);
        e_done  = (age != 0) && (age == life(cur));
        check("ready",    a_ready,  e_ready);
        check("busy",     a_busy,   !e_ready);
        check("src_a",    a_src_a,  e_src_a);
        check("src_b",    a_src_b,  e_src_b);
        check("alu_op",   a_alu_op, e_alu);
        check("dest_reg", a_dest,   e_dest);
        check("we",       a_we,     e_we);
        check("done",     a_done,   e_done);
        check("count8",   a_count,  count % 256);
        check("count2",   b_count,  count % 4);
        check("b_we",     b_we,     e_we);
        check("b_done",   b_done,   e_done);
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] i, output logic acc);
        reset       = r;
        instr_valid = v;
        instr       = i;
        acc         = 1'b0;
        @(posedge clk);
        cyc++;
        if (r) begin
            age   = 0;
            cur   = 8'd0;
            count = 0;
        end else if (age == 0) begin
            if (v) begin
                age = 1;
                cur = i;
                acc = 1'b1;
            end
        end else if (age == life(cur)) begin
            age = 0;
            count++;
        end else begin
            age++;
        end
        #1;
        compare_all();
        if (a_we === 1'b1) begin
            we_cycle_log.push_back(cyc);
            dest_log.push_back(int'(a_dest));
        end
    endtask

    // Upstream that holds each instruction with valid high until it is accepted.
    task automatic send_queue(input logic [7:0] q[$]);
        logic acc;
        int   guard = 0;
        while (q.size() > 0 && guard < 100) begin
            step(1'b0, 1'b1, q[0], acc);
            if (acc) void'(q.pop_front());
            guard++;
        end
        check("send_timeout", q.size(), 0);
    endtask

    initial begin
        logic       acc;
        logic [7:0] q[$];
        logic [7:0] held;
        logic       hold_v;

        // Single op
        step(1'b1, 1'b1, 8'hFF, acc);
        step(1'b1, 1'b0, 8'h00, acc);
        check("rst_ready", a_ready, 1'b1);
        check("rst_count", a_count, 8'd0);
        step(1'b0, 1'b1, 8'b01_10_01_00, acc);
        check("dec_src_a", a_src_a, 2'd1);
        check("dec_src_b", a_src_b, 2'd0);
        step(1'b0, 1'b0, 8'h00, acc);
        check("ex_alu", a_alu_op, 2'd1);
        step(1'b0, 1'b0, 8'h00, acc);
        check("wb_we", a_we, 1'b1);
        check("wb_dest", a_dest, 2'd2);
        check("wb_done", a_done, 1'b1);
        step(1'b0, 1'b0, 8'h00, acc);
        check("single_count", a_count, 8'd1);

        // NOP: ready again after two further edges
        step(1'b0, 1'b1, 8'b11_11_00_00, acc);
        step(1'b0, 1'b0, 8'h00, acc);
        check("nop_done", a_done, 1'b1);
        step(1'b0, 1'b0, 8'h00, acc);
        check("nop_ready", a_ready, 1'b1);

        // Back-to-back with valid held high
        we_cycle_log.delete();
        dest_log.delete();
        q = '{8'b00_01_10_11, 8'b10_11_00_01, 8'b01_00_11_10};
        send_queue(q);
        repeat (4) step(1'b0, 1'b0, 8'h00, acc);
        check("b2b_we_n", we_cycle_log.size(), 3);
        if (we_cycle_log.size() == 3) begin
            check("b2b_gap1", we_cycle_log[1] - we_cycle_log[0], 4);
            check("b2b_gap2", we_cycle_log[2] - we_cycle_log[1], 4);
            check("b2b_dest0", dest_log[0], 1);
            check("b2b_dest1", dest_log[1], 3);
            check("b2b_dest2", dest_log[2], 0);
        end

        // Valid while busy: instr changes during DECODE/EXECUTE
        step(1'b0, 1'b1, 8'b00_10_01_01, acc);
        step(1'b0, 1'b1, 8'b11_01_10_10, acc);
        step(1'b0, 1'b1, 8'b10_00_11_11, acc);
        check("busy_latched_src_a", a_src_a, 2'd1);
        step(1'b0, 1'b1, 8'b10_00_11_11, acc);
        step(1'b0, 1'b1, 8'b10_00_11_11, acc);
        check("busy_new_accept", acc, 1'b1);
        repeat (3) step(1'b0, 1'b0, 8'h00, acc);

        // Reset during WRITEBACK
        step(1'b0, 1'b1, 8'b00_11_01_10, acc);
        step(1'b0, 1'b0, 8'h00, acc);
        step(1'b0, 1'b0, 8'h00, acc);
        check("pre_rst_we", a_we, 1'b1);
        step(1'b1, 1'b1, 8'h55, acc);
        check("wbrst_we", a_we, 1'b0);
        check("wbrst_done", a_done, 1'b0);
        check("wbrst_count", a_count, 8'd0);
        check("wbrst_ready", a_ready, 1'b1);

        // Wrap on the 2-bit counter: 5 retires from zero
        q = '{8'h11, 8'hE4, 8'h27, 8'h9B, 8'h42};
        send_queue(q);
        repeat (4) step(1'b0, 1'b0, 8'h00, acc);
        check("wrap_count2", b_count, 2'd1);
        check("wrap_count8", a_count, 8'd5);

        // Random traffic: mostly well-behaved upstream, occasional resets and glitching instr
        hold_v = 1'b0;
        held   = 8'h00;
        for (int k = 0; k < 600; k++) begin
            logic r;
            r = ($urandom_range(0, 49) == 0);
            if (!hold_v) begin
                hold_v = ($urandom_range(0, 1) == 1);
                held   = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                held = 8'($urandom);
            end
            step(r, hold_v, held, acc);
            if (acc) hold_v = 1'b0;
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
